// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// Holds the word/PC widths, the queue entry layout and a ceil-log2 helper.
package ifq_pkg;
    localparam int IW_W = 16;
    localparam int PC_W = 16;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [IW_W-1:0] iw;
    } ifq_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction
endpackage

// File: rtl/ifetch_prefetch_queue_if.sv
// Memory-side request/response bus and IF-side instruction handshake of the prefetch queue.
// The master modport is the queue; the slave modport is memory plus the IF stage.
interface ifetch_prefetch_queue_if import ifq_pkg::*; #(
    parameter int DEPTH = 4
);
    localparam int QW = clog2(DEPTH) + 1;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [IW_W-1:0] imem_rdata;
    logic            iw_valid;
    logic [IW_W-1:0] iw;
    logic [PC_W-1:0] iw_pc;
    logic            iw_ready;
    logic [QW-1:0]   q_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output iw_valid, iw, iw_pc, q_count,
        input  iw_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  iw_valid, iw, iw_pc, q_count,
        output iw_ready
    );
endinterface

// File: rtl/ifq_chk.sv
// Property checkers for the prefetch queue: FIFO overflow and counter consistency.
// Bound in by instantiation from the FIFO and the top level.
module ifq_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic clr,
    input logic push,
    input logic pop_en,
    input logic full
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop_en && !clr));
endmodule

module ifq_top_chk #(
    parameter int OW = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic [OW-1:0] outstanding,
    input logic [OW-1:0] discard,
    input logic [OW-1:0] tag_count
);
    a_discard_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        discard <= outstanding);
    a_tags_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == outstanding);
endmodule

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with clear, push, pop, combinational head and occupancy.
// The head reads as zero when empty so consumers never see stale storage.
module ifq_fifo import ifq_pkg::*; #(
    parameter int  DEPTH = 4,
    parameter int  W     = 32,
    localparam int PW    = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CW    = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          empty_s;
    logic          full_s;
    logic          push_en_s;
    logic          pop_en_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Effective push/pop qualification from occupancy.
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        full_s    = (count_r == DEPTH_C);
        pop_en_s  = pop && !empty_s;
        push_en_s = push && (!full_s || pop_en_s);
        dout      = empty_s ? {W{1'b0}} : mem_r[rd_ptr_r];
    end

    // Pointer and occupancy registers; clear has priority over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_en_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_en_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r <= count_r + CW'(push_en_s) - CW'(pop_en_s);
        end
    end

    // Entry storage; unreset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_en_s && !clr) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign count = count_r;

    ifq_fifo_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .push   (push),
        .pop_en (pop_en_s),
        .full   (full_s)
    );
endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Decoupled instruction prefetch unit: credit-limited in-order memory requests,
// a PC tag queue for in-flight requests, and an instruction FIFO toward IF.
module ifetch_prefetch_queue import ifq_pkg::*; #(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    ifetch_prefetch_queue_if.master bus
);
    localparam int QW = clog2(DEPTH) + 1;
    localparam int OW = clog2(MAX_OUT) + 1;
    localparam int SW = QW + 1;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [SW-1:0] DEPTH_C   = SW'(DEPTH);

    logic [PC_W-1:0] fetch_pc_r;
    logic [OW-1:0]   outstanding_r;
    logic [OW-1:0]   discard_r;
    logic [QW-1:0]   q_count_s;
    logic [OW-1:0]   tag_count_s;
    logic [PC_W-1:0] tag_pc_s;
    logic [SW-1:0]   occupancy_s;
    logic            req_s;
    logic            grant_s;
    logic            keep_s;
    logic            pop_s;
    ifq_entry_t      push_entry_s;
    ifq_entry_t      head_entry_s;

    // Issue credit check and response routing.
    always_comb begin
        occupancy_s     = SW'(q_count_s) + SW'(outstanding_r);
        req_s           = reset_n && !redirect && !halt &&
                          (outstanding_r < MAX_OUT_C) && (occupancy_s < DEPTH_C);
        grant_s         = req_s && bus.imem_gnt;
        keep_s          = bus.imem_rvalid && (discard_r == {OW{1'b0}}) && !redirect;
        pop_s           = bus.iw_ready && !redirect;
        push_entry_s.pc = tag_pc_s;
        push_entry_s.iw = bus.imem_rdata;
    end

    // Fetch address: redirect wins, otherwise advance on each grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
        end else if (grant_s) begin
            fetch_pc_r <= fetch_pc_r + PC_W'(1);
        end
    end

    // In-flight and to-be-dropped response counters. A redirect marks every
    // response still owed after this cycle as stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_r <= {OW{1'b0}};
            discard_r     <= {OW{1'b0}};
        end else begin
            outstanding_r <= outstanding_r + OW'(grant_s) - OW'(bus.imem_rvalid);
            if (redirect) begin
                discard_r <= outstanding_r - OW'(bus.imem_rvalid);
            end else if (bus.imem_rvalid && (discard_r != {OW{1'b0}})) begin
                discard_r <= discard_r - OW'(1);
            end
        end
    end

    ifq_fifo #(.DEPTH(DEPTH), .W($bits(ifq_entry_t))) u_queue (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (redirect),
        .push  (keep_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (head_entry_s),
        .count (q_count_s)
    );

    ifq_fifo #(.DEPTH(MAX_OUT), .W(PC_W)) u_tags (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (1'b0),
        .push  (grant_s),
        .pop   (bus.imem_rvalid),
        .din   (fetch_pc_r),
        .dout  (tag_pc_s),
        .count (tag_count_s)
    );

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.iw_valid  = (q_count_s != {QW{1'b0}});
    assign bus.iw        = head_entry_s.iw;
    assign bus.iw_pc     = head_entry_s.pc;
    assign bus.q_count   = q_count_s;

    ifq_top_chk #(.OW(OW)) u_chk (
        .clk         (clk),
        .rst_n       (reset_n),
        .outstanding (outstanding_r),
        .discard     (discard_r),
        .tag_count   (tag_count_s)
    );
endmodule
